// File: rtl/lc3b_mem_arbiter_if.sv
// rtl/lc3b_mem_arbiter_if.sv - core/loader request ports and shared memory bus of the arbiter
interface lc3b_mem_arbiter_if;
  logic        c_req;
  logic        c_wr;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_ack;
  logic [15:0] c_rdata;

  logic        l_req;
  logic        l_wr;
  logic [15:0] l_addr;
  logic [15:0] l_wdata;
  logic        l_ack;
  logic [15:0] l_rdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [1:0]  grant;
  logic        bus_err;

  modport slave (
    input  c_req, c_wr, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  l_req, l_wr, l_addr, l_wdata,
    output l_ack, l_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output grant, bus_err
  );

  modport master (
    output c_req, c_wr, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output l_req, l_wr, l_addr, l_wdata,
    input  l_ack, l_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  grant, bus_err
  );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// rtl/lc3b_mem_arbiter.sv - round-robin core/loader arbiter for a single memory port with timeout
module lc3b_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  lc3b_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BUSY = 8'(TIMEOUT - 1);

  state_t      state;
  logic        owner;        // 0 core, 1 loader
  logic        last_served;  // 0 core, 1 loader
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  busy_cnt;
  logic [15:0] c_rdata_q;
  logic [15:0] l_rdata_q;
  logic        c_ack_q;
  logic        l_ack_q;
  logic        bus_err_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [1:0]  grant_q;

  logic        pick_loader;
  logic        sel_wr;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // Loader wins alone, or on a tie when the core was served last.
  always_comb begin
    pick_loader = bus.l_req && (!bus.c_req || !last_served);
    sel_wr      = pick_loader ? bus.l_wr    : bus.c_wr;
    sel_addr    = pick_loader ? bus.l_addr  : bus.c_addr;
    sel_wdata   = pick_loader ? bus.l_wdata : bus.c_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      busy_cnt    <= 8'd0;
      c_rdata_q   <= 16'h0000;
      l_rdata_q   <= 16'h0000;
      c_ack_q     <= 1'b0;
      l_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.c_req || bus.l_req) begin
            owner    <= pick_loader;
            wr_q     <= sel_wr;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            grant_q  <= pick_loader ? 2'b10 : 2'b01;
            mem_rd_q <= !sel_wr;
            mem_wr_q <= sel_wr;
            busy_cnt <= 8'd0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          // mem_ready takes priority over a timeout landing in the same cycle.
          if (bus.mem_ready || busy_cnt == LAST_BUSY) begin
            state     <= ACK;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            c_ack_q   <= !owner;
            l_ack_q   <= owner;
            bus_err_q <= !bus.mem_ready;
            if (bus.mem_ready && !wr_q) begin
              if (owner) begin
                l_rdata_q <= bus.mem_rdata;
              end else begin
                c_rdata_q <= bus.mem_rdata;
              end
            end
          end
          if (!bus.mem_ready) begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end

        ACK: begin
          c_ack_q     <= 1'b0;
          l_ack_q     <= 1'b0;
          bus_err_q   <= 1'b0;
          grant_q     <= 2'b00;
          last_served <= owner;
          busy_cnt    <= 8'd0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.c_ack     = c_ack_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.l_ack     = l_ack_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.grant     = grant_q;
  assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb/tb_lc3b_mem_arbiter.sv - scoreboard bench for lc3b_mem_arbiter with a memory responder
module tb_lc3b_mem_arbiter;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit          who;       // 0 core, 1 loader
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          d;         // BUSY cycles before mem_ready; >= TIMEOUT means never
    int          exp_start;
    logic [15:0] exp_cr;
    logic [15:0] exp_lr;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  txn_t mem_q[$];
  txn_t ack_q[$];
  int   start_q[$];

  bit          m_ls;
  logic [15:0] m_cr;
  logic [15:0] m_lr;

  lc3b_mem_arbiter_if bus ();

  lc3b_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h (cycle %0d)", name, act, cyc);
  endtask

  task automatic end_sim();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic int busy_len(input int d);
    return (d + 1 < TIMEOUT) ? d + 1 : TIMEOUT;
  endfunction

  function automatic txn_t mk(input bit who, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int d, input logic [15:0] rdata);
    txn_t t;
    t.who = who; t.wr = wr; t.addr = addr; t.wdata = wdata; t.d = d; t.rdata = rdata;
    t.exp_start = -1; t.exp_cr = 16'h0; t.exp_lr = 16'h0;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit who);
    int sel;
    int d;
    sel = int'($urandom_range(0, 9));
    d = (sel == 0) ? TIMEOUT : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
    return mk(who, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), d, 16'($urandom));
  endfunction

  // Reference model: transactions complete in arbitration order, reads update the owner's rdata.
  task automatic model_push(input txn_t t_in, input int start, output int next_start);
    txn_t t;
    t = t_in;
    t.exp_start = start;
    if (!t.wr && t.d < TIMEOUT) begin
      if (t.who) m_lr = t.rdata; else m_cr = t.rdata;
    end
    t.exp_cr = m_cr;
    t.exp_lr = m_lr;
    m_ls = t.who;
    mem_q.push_back(t);
    ack_q.push_back(t);
    next_start = start + busy_len(t.d) + 2;
  endtask

  task automatic wait_acks(input bit need_c, input bit need_l);
    int budget;
    budget = 0;
    while ((need_c || need_l) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (bus.c_ack) begin bus.c_req = 1'b0; need_c = 1'b0; end
      if (bus.l_ack) begin bus.l_req = 1'b0; need_l = 1'b0; end
      if (bus.grant == 2'b01) begin
        bus.c_wr = 1'($urandom); bus.c_addr = 16'($urandom); bus.c_wdata = 16'($urandom);
      end
      if (bus.grant == 2'b10) begin
        bus.l_wr = 1'($urandom); bus.l_addr = 16'($urandom); bus.l_wdata = 16'($urandom);
      end
    end
    if (need_c || need_l) begin
      fail("ack_wait_expired", {30'd0, need_l, need_c});
      end_sim();
    end
    @(negedge clk);
    check("idle_grant", bus.grant, 2'b00);
    check("idle_strobes", {bus.mem_rd, bus.mem_wr}, 2'b00);
  endtask

  task automatic run_trial(input bit creq, input bit lreq, input txn_t ct, input txn_t lt);
    int s;
    int s2;
    s = cyc + 1;
    if (creq && lreq) begin
      if (m_ls) begin model_push(ct, s, s2); model_push(lt, s2, s); end
      else begin model_push(lt, s, s2); model_push(ct, s2, s); end
    end else if (creq) begin
      model_push(ct, s, s2);
    end else begin
      model_push(lt, s, s2);
    end
    if (creq) begin
      bus.c_wr = ct.wr; bus.c_addr = ct.addr; bus.c_wdata = ct.wdata; bus.c_req = 1'b1;
    end
    if (lreq) begin
      bus.l_wr = lt.wr; bus.l_addr = lt.addr; bus.l_wdata = lt.wdata; bus.l_req = 1'b1;
    end
    wait_acks(creq, lreq);
  endtask

  task automatic reset_mid_op();
    txn_t t;
    int s2;
    t = mk(1'b0, 1'b0, 16'($urandom), 16'h0, TIMEOUT + 40, 16'h0);
    t.exp_start = cyc + 1;
    mem_q.push_back(t);
    bus.c_wr = 1'b0; bus.c_addr = t.addr; bus.c_req = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_strobes", {bus.mem_rd, bus.mem_wr}, 2'b00);
    check("rst_grant", bus.grant, 2'b00);
    check("rst_acks_err", {bus.c_ack, bus.l_ack, bus.bus_err}, 3'b000);
    check("rst_rdata", {bus.c_rdata, bus.l_rdata}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    m_cr = 16'h0; m_lr = 16'h0; m_ls = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_ack", {bus.c_ack, bus.l_ack}, 2'b00);
    t = mk(1'b0, 1'b0, 16'($urandom), 16'h0, int'($urandom_range(0, 3)), 16'($urandom));
    model_push(t, cyc + 1, s2);
    bus.c_addr = t.addr;
    reset = 1'b1;
    wait_acks(1'b1, 1'b0);
  endtask

  // Memory responder: checks each bus transaction and answers per the queued plan.
  initial begin : responder
    txn_t it;
    int   nb;
    bit   aborted;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.mem_ready = 1'b0;
      end else if (bus.mem_rd || bus.mem_wr) begin
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_op", bus.mem_addr);
        end else begin
          it = mem_q.pop_front();
          start_q.push_back(cyc);
          if (it.exp_start >= 0) check("busy_start_cycle", cyc, it.exp_start);
          check("mem_addr", bus.mem_addr, it.addr);
          check("mem_strobes", {bus.mem_rd, bus.mem_wr}, it.wr ? 2'b01 : 2'b10);
          if (it.wr) check("mem_wdata", bus.mem_wdata, it.wdata);
          nb = 0;
          aborted = 1'b0;
          forever begin
            if (nb == it.d) begin
              bus.mem_ready = 1'b1; bus.mem_rdata = it.rdata;
            end else begin
              bus.mem_ready = 1'b0; bus.mem_rdata = 16'($urandom);
            end
            nb++;
            @(negedge clk);
            if (!reset) begin aborted = 1'b1; break; end
            if (!(bus.mem_rd || bus.mem_wr) || nb > TIMEOUT + 2) break;
          end
          bus.mem_ready = 1'b0;
          if (aborted) void'(start_q.pop_back());
          else check("strobe_cycles", nb, busy_len(it.d));
        end
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = 16'($urandom);
      end
    end
  end

  // Ack monitor: pops the scoreboard whenever an ack pulse appears.
  initial begin : monitor
    txn_t t;
    int   st;
    forever begin
      @(negedge clk);
      if (reset && (bus.c_ack || bus.l_ack)) begin
        if (bus.c_ack && bus.l_ack) begin
          fail("dual_ack", {30'd0, bus.l_ack, bus.c_ack});
        end else if (ack_q.size() == 0) begin
          fail("unexpected_ack", {30'd0, bus.l_ack, bus.c_ack});
        end else begin
          t = ack_q.pop_front();
          check("ack_owner", bus.l_ack, t.who);
          check("bus_err", bus.bus_err, t.d >= TIMEOUT);
          check("c_rdata", bus.c_rdata, t.exp_cr);
          check("l_rdata", bus.l_rdata, t.exp_lr);
          check("ack_grant", bus.grant, t.who ? 2'b10 : 2'b01);
          check("ack_strobes", {bus.mem_rd, bus.mem_wr}, 2'b00);
          if (start_q.size() == 0) fail("ack_without_busy", cyc);
          else begin
            st = start_q.pop_front();
            check("ack_latency", cyc - st, busy_len(t.d));
          end
        end
      end else if (reset) begin
        check("bus_err_without_ack", bus.bus_err, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #900000;
    fail("watchdog", cyc);
    end_sim();
  end

  initial begin : stimulus
    bit   cr;
    bit   lr;
    int   sel;
    bus.c_req = 1'b0; bus.c_wr = 1'b0; bus.c_addr = 16'h0; bus.c_wdata = 16'h0;
    bus.l_req = 1'b0; bus.l_wr = 1'b0; bus.l_addr = 16'h0; bus.l_wdata = 16'h0;
    m_ls = 1'b1; m_cr = 16'h0; m_lr = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {bus.mem_rd, bus.mem_wr}, 2'b00);
    check("reset_acks_err", {bus.c_ack, bus.l_ack, bus.bus_err}, 3'b000);
    check("reset_grant", bus.grant, 2'b00);
    check("reset_rdata", {bus.c_rdata, bus.l_rdata}, 32'h0);
    check("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0);
    reset = 1'b1;

    run_trial(1'b1, 1'b1, mk(1'b0, 1'b0, 16'h1111, 16'h0, 1, 16'hA5A5),
              mk(1'b1, 1'b1, 16'h2222, 16'h5A5A, 0, 16'h0));
    run_trial(1'b1, 1'b0, mk(1'b0, 1'b0, 16'h3000, 16'h0, 0, 16'h1234), rand_txn(1'b1));
    run_trial(1'b0, 1'b1, rand_txn(1'b0), mk(1'b1, 1'b1, 16'h0040, 16'hBEEF, 2, 16'hDEAD));
    run_trial(1'b1, 1'b0, mk(1'b0, 1'b0, 16'h5555, 16'h0, TIMEOUT, 16'h9999), rand_txn(1'b1));
    run_trial(1'b1, 1'b0, mk(1'b0, 1'b0, 16'h6666, 16'h0, TIMEOUT - 1, 16'h7777), rand_txn(1'b1));

    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sel = int'($urandom_range(0, 2));
      cr = (sel != 1);
      lr = (sel != 0);
      run_trial(cr, lr, rand_txn(1'b0), rand_txn(1'b1));
    end

    reset_mid_op();

    for (int i = 0; i < 10; i++) begin
      run_trial(1'b1, 1'b1, rand_txn(1'b0), rand_txn(1'b1));
    end

    repeat (3) @(negedge clk);
    check("ack_queue_drained", ack_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    end_sim();
  end
endmodule
